// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock timebase: moduli, 1 Hz divider, default counter shape.
package clock_pkg;

    localparam int unsigned DEF_STAGES  = 3;
    localparam int unsigned DEF_W       = 8;

    localparam int unsigned SEC_MOD_M1  = 59;
    localparam int unsigned MIN_MOD_M1  = 59;
    localparam int unsigned HOUR_MOD_M1 = 23;

    localparam int unsigned HZ1_DIV_M1  = 100_000_000 - 1;

endpackage

// File: rtl/modulo_stage.sv
// One modulo counter stage: up/down with runtime comparand, preset load and single step.
// wrap is combinational so the parent can ripple carry through all stages in one edge.
module modulo_stage
    import clock_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         TICK,
    input  logic         RESET_N,
    input  logic         inc,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         adj,
    input  logic [W-1:0] comparand,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_step;

    // Next value for one step; an out-of-range value snaps to 0 (up) or to the comparand (down).
    always_comb begin
        wrap   = 1'b0;
        w_step = r_q;
        if (up_dn) begin
            wrap   = (r_q >= comparand);
            w_step = wrap ? '0 : r_q + W'(1);
        end else begin
            wrap = (r_q == '0);
            if (wrap || (r_q > comparand)) begin
                w_step = comparand;
            end else begin
                w_step = r_q - W'(1);
            end
        end
    end

    // Stage register: load beats adjust beats count.
    always_ff @(posedge TICK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_val;
        end else if (adj || inc) begin
            r_q <= w_step;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/cascaded_modulo_counter.sv
// Cascaded modulo counter for the clock timebase (e.g. hours:minutes:seconds).
// Carry/borrow ripples combinationally so every stage updates on the same TICK edge.
module cascaded_modulo_counter
    import clock_pkg::*;
#(
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned W      = DEF_W
) (
    input  logic                      TICK,
    input  logic                      RESET_N,
    input  logic                      ENABLE,
    input  logic                      UP_DN,
    input  logic [STAGES*W-1:0]       COMPARAND,
    input  logic                      LOAD,
    input  logic [STAGES*W-1:0]       LOAD_VALUE,
    input  logic                      ADJ,
    input  logic [$clog2(STAGES)-1:0] ADJ_SEL,
    output logic [STAGES*W-1:0]       Q_OUT,
    output logic [STAGES-1:0]         CARRY,
    output logic                      ROLLOVER
);

    localparam int unsigned SEL_W = $clog2(STAGES);

    logic              w_cnt;
    logic [STAGES-1:0] w_inc;
    logic [STAGES-1:0] w_wrap;
    logic [STAGES-1:0] w_adj;
    logic [STAGES-1:0] r_carry;
    logic              r_rollover;

    // Counting only happens on edges with no load or adjust pending.
    assign w_cnt = ENABLE && !LOAD && !ADJ;

    // Increment chain: stage k steps when every lower stage steps and wraps.
    always_comb begin
        logic v_acc;
        v_acc = w_cnt;
        w_inc = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            w_inc[k] = v_acc;
            v_acc    = v_acc && w_wrap[k];
        end
    end

    // Adjust decode; an out-of-range select matches no stage.
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            w_adj[k] = ADJ && (ADJ_SEL == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        modulo_stage #(
            .W (W)
        ) u_stage (
            .TICK      (TICK),
            .RESET_N   (RESET_N),
            .inc       (w_inc[k]),
            .up_dn     (UP_DN),
            .load      (LOAD),
            .load_val  (LOAD_VALUE[k*W +: W]),
            .adj       (w_adj[k]),
            .comparand (COMPARAND[k*W +: W]),
            .q         (Q_OUT[k*W +: W]),
            .wrap      (w_wrap[k])
        );
    end

    // Wrap pulses are only raised by counting; load, adjust and idle edges clear them.
    always_ff @(posedge TICK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_carry    <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_carry    <= w_inc & w_wrap;
            r_rollover <= w_inc[STAGES-1] && w_wrap[STAGES-1];
        end
    end

    assign CARRY    = r_carry;
    assign ROLLOVER = r_rollover;

endmodule

// File: tb/tb_cascaded_modulo_counter.sv
// Directed self-checking bench for cascaded_modulo_counter in the 3-stage h:m:s configuration.
module tb_cascaded_modulo_counter;
    import clock_pkg::*;

    localparam int unsigned STAGES = 3;
    localparam int unsigned W      = 8;

    logic                  TICK;
    logic                  RESET_N;
    logic                  ENABLE;
    logic                  UP_DN;
    logic [STAGES*W-1:0]   COMPARAND;
    logic                  LOAD;
    logic [STAGES*W-1:0]   LOAD_VALUE;
    logic                  ADJ;
    logic [1:0]            ADJ_SEL;
    logic [STAGES*W-1:0]   Q_OUT;
    logic [STAGES-1:0]     CARRY;
    logic                  ROLLOVER;

    int n_vec;
    int n_err;

    cascaded_modulo_counter #(
        .STAGES (STAGES),
        .W      (W)
    ) dut (
        .TICK       (TICK),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .UP_DN      (UP_DN),
        .COMPARAND  (COMPARAND),
        .LOAD       (LOAD),
        .LOAD_VALUE (LOAD_VALUE),
        .ADJ        (ADJ),
        .ADJ_SEL    (ADJ_SEL),
        .Q_OUT      (Q_OUT),
        .CARRY      (CARRY),
        .ROLLOVER   (ROLLOVER)
    );

    initial TICK = 1'b0;
    always #5 TICK = ~TICK;

    function automatic logic [23:0] hms(input int h, input int m, input int s);
        return {8'(h), 8'(m), 8'(s)};
    endfunction

    task automatic tick();
        @(posedge TICK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [23:0] q, input logic [2:0] c, input logic r);
        chk({tag, ".q"}, 32'(Q_OUT), 32'(q));
        chk({tag, ".carry"}, 32'(CARRY), 32'(c));
        chk({tag, ".rollover"}, 32'(ROLLOVER), 32'(r));
    endtask

    int          n_roll;
    int          roll_idx;
    logic [2:0]  roll_carry;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        RESET_N    = 1'b0;
        ENABLE     = 1'b0;
        UP_DN      = 1'b1;
        COMPARAND  = hms(HOUR_MOD_M1, MIN_MOD_M1, SEC_MOD_M1);
        LOAD       = 1'b0;
        LOAD_VALUE = '0;
        ADJ        = 1'b0;
        ADJ_SEL    = '0;

        // 1. Reset, then a full day of up counts
        #12;
        chk_all("reset", hms(0, 0, 0), 3'b000, 1'b0);
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        n_roll     = 0;
        roll_idx   = -1;
        roll_carry = '0;
        for (int i = 0; i < 86400; i++) begin
            tick();
            if (i == 59) chk_all("day.first_min", hms(0, 1, 0), 3'b001, 1'b0);
            if (i == 3599) chk_all("day.first_hour", hms(1, 0, 0), 3'b011, 1'b0);
            if (ROLLOVER === 1'b1) begin
                n_roll++;
                roll_idx   = i;
                roll_carry = CARRY;
            end
        end
        chk("day.q_end", 32'(Q_OUT), 32'(hms(0, 0, 0)));
        chk("day.n_rollover", 32'(n_roll), 32'd1);
        chk("day.rollover_edge", 32'(roll_idx), 32'd86399);
        chk("day.rollover_carry", 32'(roll_carry), 32'b111);

        // 2. Minute rollover, then into the next hour
        LOAD = 1'b1; LOAD_VALUE = hms(0, 0, 59);
        tick();
        chk_all("min.load", hms(0, 0, 59), 3'b000, 1'b0);
        LOAD = 1'b0;
        tick();
        chk_all("min.wrap", hms(0, 1, 0), 3'b001, 1'b0);
        ticks(3540);
        chk_all("min.hour", hms(1, 0, 0), 3'b011, 1'b0);
        ENABLE = 1'b0;
        tick();
        chk_all("min.idle", hms(1, 0, 0), 3'b000, 1'b0);
        ENABLE = 1'b1;

        // 3. Down count with borrow through every stage
        UP_DN = 1'b0;
        LOAD = 1'b1; LOAD_VALUE = hms(0, 0, 0);
        tick();
        LOAD = 1'b0;
        tick();
        chk_all("down.borrow", hms(23, 59, 59), 3'b111, 1'b1);
        tick();
        chk_all("down.next", hms(23, 59, 58), 3'b000, 1'b0);

        // 4. Adjust isolation and load priority (ENABLE stays high)
        UP_DN = 1'b1;
        LOAD = 1'b1; LOAD_VALUE = hms(5, 59, 10);
        tick();
        LOAD = 1'b0; ADJ = 1'b1; ADJ_SEL = 2'd1;
        tick();
        chk_all("adj.min_up", hms(5, 0, 10), 3'b000, 1'b0);
        UP_DN = 1'b0; ADJ_SEL = 2'd0;
        tick();
        chk_all("adj.sec_dn", hms(5, 0, 9), 3'b000, 1'b0);
        ADJ_SEL = 2'd2;
        tick();
        chk_all("adj.hour_dn", hms(4, 0, 9), 3'b000, 1'b0);
        ADJ_SEL = 2'd3;
        tick();
        chk_all("adj.bad_sel", hms(4, 0, 9), 3'b000, 1'b0);
        LOAD = 1'b1; LOAD_VALUE = hms(7, 7, 7); ADJ_SEL = 2'd0;
        tick();
        chk_all("adj.load_wins", hms(7, 7, 7), 3'b000, 1'b0);
        LOAD = 1'b0; ADJ = 1'b0;

        // 5a. Out-of-range hour, up count
        UP_DN = 1'b1;
        LOAD = 1'b1; LOAD_VALUE = hms(30, 0, 0);
        tick();
        chk("oor.load_verbatim", 32'(Q_OUT), 32'(hms(30, 0, 0)));
        LOAD = 1'b0;
        tick();
        chk_all("oor.first", hms(30, 0, 1), 3'b000, 1'b0);
        ticks(3599);
        chk_all("oor.up_wrap", hms(0, 0, 0), 3'b111, 1'b1);

        // 5b. Out-of-range hour, down count snaps to comparand without wrap
        UP_DN = 1'b0;
        LOAD = 1'b1; LOAD_VALUE = hms(30, 0, 0);
        tick();
        LOAD = 1'b0;
        tick();
        chk_all("oor.down", hms(23, 59, 59), 3'b011, 1'b0);

        // 5c. Comparand lowered below the current hour
        UP_DN = 1'b1;
        LOAD = 1'b1; LOAD_VALUE = hms(15, 59, 59);
        tick();
        LOAD = 1'b0; COMPARAND = hms(11, 59, 59);
        tick();
        chk_all("cmp.change", hms(0, 0, 0), 3'b111, 1'b1);

        // 5d. Comparand 0 on the middle stage passes carry straight through
        COMPARAND = hms(23, 0, 59);
        LOAD = 1'b1; LOAD_VALUE = hms(3, 0, 58);
        tick();
        LOAD = 1'b0;
        tick();
        chk("cmp0.pre", 32'(Q_OUT), 32'(hms(3, 0, 59)));
        tick();
        chk_all("cmp0.pass", hms(4, 0, 0), 3'b011, 1'b0);
        COMPARAND = hms(HOUR_MOD_M1, MIN_MOD_M1, SEC_MOD_M1);

        // 6. Asynchronous reset while CARRY is high
        LOAD = 1'b1; LOAD_VALUE = hms(0, 0, 59);
        tick();
        LOAD = 1'b0;
        tick();
        chk_all("areset.pre", hms(0, 1, 0), 3'b001, 1'b0);
        #2 RESET_N = 1'b0;
        #1;
        chk_all("areset.cleared", hms(0, 0, 0), 3'b000, 1'b0);
        #1 RESET_N = 1'b1;
        tick();
        chk_all("areset.resume", hms(0, 0, 1), 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
